// File: rtl/alu_uart_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_uart_ctrl_pkg
// Shared definitions for the UART-fronted ALU controller:
//   - default parameter values (data width, opcode width, timeout sizing)
//   - 3-bit FSM state encoding
//   - small state-classification helpers used by the controller
// No ports (package).
// -----------------------------------------------------------------------------
package alu_uart_ctrl_pkg;

    localparam int NB_DATA_DEF       = 8;
    localparam int NB_OP_DEF         = 6;
    localparam int NB_TIMEOUT_DEF    = 16;
    localparam int TIMEOUT_TICKS_DEF = 1600;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    // States in which a received byte belongs to the frame being assembled.
    function automatic logic is_rx_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_WAIT_B) || (s == ST_WAIT_OP);
    endfunction

    // States in which the inter-byte timeout is running.
    function automatic logic is_count_state(input state_t s);
        return (s == ST_WAIT_B) || (s == ST_WAIT_OP);
    endfunction

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_uart_ctrl_if
// Bundles the UART receive/transmit handshakes and the ALU operand/result
// signals seen by the controller.
//   slave  modport : the controller (consumes i_*, drives o_*)
//   master modport : the UART/ALU environment (drives i_*, consumes o_*)
// Signals:
//   i_tick        baud-generator overflow pulse (16x oversample)
//   i_rx_done     one-cycle pulse, i_rx_data holds a received byte
//   i_rx_data     received byte
//   i_tx_done     one-cycle pulse, transmitter finished its byte
//   i_alu_result  combinational ALU result
//   o_data_a/b    registered ALU operands
//   o_op          registered ALU opcode
//   o_tx_start    one-cycle transmit request
//   o_tx_data     byte to transmit
//   o_busy        controller is executing/sending
//   o_timeout     one-cycle pulse on frame abort
//   o_overrun     one-cycle pulse on dropped byte
// -----------------------------------------------------------------------------
interface alu_uart_ctrl_if
    import alu_uart_ctrl_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) ();

    logic               i_tick;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;

    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_busy;
    logic               o_timeout;
    logic               o_overrun;

    modport slave (
        input  i_tick, i_rx_done, i_rx_data, i_tx_done, i_alu_result,
        output o_data_a, o_data_b, o_op, o_tx_start, o_tx_data,
               o_busy, o_timeout, o_overrun
    );

    modport master (
        output i_tick, i_rx_done, i_rx_data, i_tx_done, i_alu_result,
        input  o_data_a, o_data_b, o_op, o_tx_start, o_tx_data,
               o_busy, o_timeout, o_overrun
    );

endinterface

// File: rtl/frame_timeout_counter.sv
// -----------------------------------------------------------------------------
// frame_timeout_counter
// Counts baud ticks between bytes of one frame and flags expiry when the
// tick that would reach TIMEOUT_TICKS arrives. Saturates instead of wrapping.
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   clear   restart the count (a byte was accepted); wins over counting
//   enable  counting allowed (frame partially received)
//   tick    baud tick pulse
//   expire  combinational: this tick ends the allowed window
// -----------------------------------------------------------------------------
module frame_timeout_counter
    import alu_uart_ctrl_pkg::*;
#(
    parameter int NB_TIMEOUT    = NB_TIMEOUT_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic expire
);

    localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_TICKS - 1);

    logic [NB_TIMEOUT-1:0] count;

    // A byte arriving on the expiring tick keeps the frame alive.
    assign expire = enable && tick && !clear && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && tick && (count != LAST)) begin
            count <= count + NB_TIMEOUT'(1);
        end
    end

endmodule

// File: rtl/alu_uart_ctrl.sv
// -----------------------------------------------------------------------------
// alu_uart_ctrl
// Assembles a three-byte frame from the UART receiver (operand A, operand B,
// opcode), lets the external combinational ALU settle for one cycle, then
// requests transmission of the result and waits for the transmitter.
// A partially received frame is abandoned if the inter-byte gap exceeds
// TIMEOUT_TICKS baud ticks; bytes arriving while a result is in flight are
// dropped and reported.
// Ports:
//   i_clk    system clock
//   i_reset  asynchronous active-high reset
//   bus      alu_uart_ctrl_if.slave (UART handshakes, ALU operands/result,
//            status pulses)
// -----------------------------------------------------------------------------
module alu_uart_ctrl
    import alu_uart_ctrl_pkg::*;
#(
    parameter int NB_DATA       = NB_DATA_DEF,
    parameter int NB_OP         = NB_OP_DEF,
    parameter int NB_TIMEOUT    = NB_TIMEOUT_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    alu_uart_ctrl_if.slave  bus
);

    state_t state;
    logic   rx_accept;
    logic   expire;

    assign rx_accept = bus.i_rx_done && is_rx_state(state);

    // Clearing on every accepted byte also covers entry to WAIT_B, since
    // that entry is caused by accepting operand A.
    frame_timeout_counter #(
        .NB_TIMEOUT    (NB_TIMEOUT),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk    (i_clk),
        .rst    (i_reset),
        .clear  (rx_accept),
        .enable (is_count_state(state)),
        .tick   (bus.i_tick),
        .expire (expire)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            bus.o_data_a   <= '0;
            bus.o_data_b   <= '0;
            bus.o_op       <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_tx_data  <= '0;
            bus.o_busy     <= 1'b0;
            bus.o_timeout  <= 1'b0;
            bus.o_overrun  <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults followed by conditional overrides
            // below; the last scheduled assignment wins, so pulses drop back
            // to 0 on every cycle that does not re-assert them.
            bus.o_tx_start <= 1'b0;
            bus.o_timeout  <= 1'b0;
            bus.o_overrun  <= bus.i_rx_done && !is_rx_state(state);

            case (state)
                ST_IDLE: begin
                    if (bus.i_rx_done) begin
                        bus.o_data_a <= bus.i_rx_data;
                        state        <= ST_WAIT_B;
                    end
                end

                ST_WAIT_B: begin
                    if (bus.i_rx_done) begin
                        bus.o_data_b <= bus.i_rx_data;
                        state        <= ST_WAIT_OP;
                    end else if (expire) begin
                        bus.o_timeout <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                ST_WAIT_OP: begin
                    if (bus.i_rx_done) begin
                        bus.o_op   <= bus.i_rx_data[NB_OP-1:0];
                        bus.o_busy <= 1'b1;
                        state      <= ST_EXEC;
                    end else if (expire) begin
                        bus.o_timeout <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                // The operand/opcode registers were loaded on the previous
                // edge; the ALU output is stable by now.
                ST_EXEC: begin
                    bus.o_tx_data  <= NB_DATA'(bus.i_alu_result);
                    bus.o_tx_start <= 1'b1;
                    state          <= ST_SEND;
                end

                ST_SEND: begin
                    state <= ST_WAIT_TX;
                end

                ST_WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        bus.o_busy <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    bus.o_busy <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_ctrl
// Frame-level bench for alu_uart_ctrl. Expected operands, opcode and result
// are kept as "last accepted frame" values and updated only where a frame
// event says they must change; the ALU itself is a small behavioural model.
// -----------------------------------------------------------------------------
module tb_alu_uart_ctrl;
    import alu_uart_ctrl_pkg::*;

    localparam int TICKS = TIMEOUT_TICKS_DEF;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_a  = 8'h00;
    logic [7:0] exp_b  = 8'h00;
    logic [5:0] exp_op = 6'h00;
    logic [7:0] exp_tx = 8'h00;

    logic [5:0] op_tab [8];

    alu_uart_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    alu_uart_ctrl #(
        .NB_DATA       (8),
        .NB_OP         (6),
        .NB_TIMEOUT    (16),
        .TIMEOUT_TICKS (TICKS)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            6'h03:   return 8'($signed(a) >>> b[2:0]);
            default: return 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result = alu_fn(bus.o_data_a, bus.o_data_b, bus.o_op);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_a"},  32'(bus.o_data_a),  32'(exp_a));
        check({tag, "_b"},  32'(bus.o_data_b),  32'(exp_b));
        check({tag, "_op"}, 32'(bus.o_op),      32'(exp_op));
        check({tag, "_tx"}, 32'(bus.o_tx_data), 32'(exp_tx));
    endtask

    task automatic check_all_zero(input string tag);
        check_regs(tag);
        check({tag, "_start"}, 32'(bus.o_tx_start), 32'd0);
        check({tag, "_busy"},  32'(bus.o_busy),     32'd0);
        check({tag, "_to"},    32'(bus.o_timeout),  32'd0);
        check({tag, "_ovr"},   32'(bus.o_overrun),  32'd0);
    endtask

    // One clock: inputs held across the edge, outputs observed 1 time unit later.
    task automatic cycle(input logic rx, input logic [7:0] data, input logic tick,
                         input logic txd);
        bus.i_rx_done = rx;
        bus.i_rx_data = data;
        bus.i_tick    = tick;
        bus.i_tx_done = txd;
        @(posedge i_clk);
        #1;
        bus.i_rx_done = 1'b0;
        bus.i_tick    = 1'b0;
        bus.i_tx_done = 1'b0;
    endtask

    // n baud ticks with occasional idle cycles between them, no bytes.
    task automatic ticks(input int n, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 8'h00, 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            if (bus.o_timeout) seen++;
        end
        check({tag, "_no_timeout"}, 32'(seen), 32'd0);
    endtask

    // ovr_at: 0 none, 1 extra byte while in EXEC, 2 extra byte while in WAIT_TX.
    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input int gap_b, input int gap_op, input logic op_tick,
                         input int ovr_at, input logic stray, input logic reset_in_tx);
        int tx_wait;
        if (stray) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            check("stray_busy", 32'(bus.o_busy), 32'd0);
            check_regs("stray");
        end

        cycle(1'b1, a, 1'b0, 1'b0);
        exp_a = a;
        check("a_busy", 32'(bus.o_busy), 32'd0);
        check_regs("byte_a");
        ticks(gap_b, "gap_b");

        cycle(1'b1, b, 1'b0, 1'b0);
        exp_b = b;
        check("b_busy", 32'(bus.o_busy), 32'd0);
        check_regs("byte_b");
        ticks(gap_op, "gap_op");

        cycle(1'b1, opb, op_tick, 1'b0);
        exp_op = opb[5:0];
        check("op_timeout", 32'(bus.o_timeout),  32'd0);
        check("op_busy",    32'(bus.o_busy),     32'd1);
        check("op_start",   32'(bus.o_tx_start), 32'd0);
        check_regs("byte_op");

        // Leaving EXEC: result latched, start request visible.
        cycle(ovr_at == 1, 8'hAA, 1'b0, 1'b0);
        exp_tx = alu_fn(exp_a, exp_b, exp_op);
        check("send_start", 32'(bus.o_tx_start), 32'd1);
        check("send_busy",  32'(bus.o_busy),     32'd1);
        check("send_ovr",   32'(bus.o_overrun),  32'(ovr_at == 1));
        check_regs("send");

        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("wtx_start", 32'(bus.o_tx_start), 32'd0);
        check("wtx_busy",  32'(bus.o_busy),     32'd1);
        check("wtx_ovr",   32'(bus.o_overrun),  32'd0);

        if (ovr_at == 2) begin
            cycle(1'b1, 8'hAA, 1'b0, 1'b0);
            check("ovr_pulse", 32'(bus.o_overrun),  32'd1);
            check("ovr_start", 32'(bus.o_tx_start), 32'd0);
            check_regs("ovr");
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            check("ovr_single", 32'(bus.o_overrun), 32'd0);
        end

        tx_wait = int'($urandom_range(0, 4));
        for (int i = 0; i < tx_wait; i++) begin
            cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
            check("hold_start", 32'(bus.o_tx_start), 32'd0);
            check("hold_busy",  32'(bus.o_busy),     32'd1);
        end

        if (reset_in_tx) begin
            #2;
            i_reset = 1'b1;
            #1;
            exp_a = 8'h00; exp_b = 8'h00; exp_op = 6'h00; exp_tx = 8'h00;
            check_all_zero("midtx_rst");
            @(posedge i_clk);
            #1;
            i_reset = 1'b0;
        end else begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            check("done_busy",  32'(bus.o_busy),     32'd0);
            check("done_start", 32'(bus.o_tx_start), 32'd0);
            check_regs("done");
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            check("idle_busy", 32'(bus.o_busy), 32'd0);
        end
    endtask

    // Partial frame followed by exactly TICKS ticks without a byte.
    task automatic timeout_frame(input logic [7:0] a, input logic [7:0] b, input logic two_bytes);
        cycle(1'b1, a, 1'b0, 1'b0);
        exp_a = a;
        check_regs("to_byte_a");
        if (two_bytes) begin
            ticks(int'($urandom_range(0, 50)), "to_gap");
            cycle(1'b1, b, 1'b0, 1'b0);
            exp_b = b;
            check_regs("to_byte_b");
        end
        ticks(TICKS - 1, "to_pre");
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("to_pulse", 32'(bus.o_timeout), 32'd1);
        check("to_busy",  32'(bus.o_busy),    32'd0);
        check_regs("to_abort");
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("to_single", 32'(bus.o_timeout), 32'd0);
        check_regs("to_after");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
        bus.i_tick    = 1'b0;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        bus.i_tx_done = 1'b0;

        #2;
        check_all_zero("reset");
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Known vector: 5 + 3.
        frame(8'h05, 8'h03, 8'h20, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        check("vec_tx", 32'(exp_tx), 32'h08);

        // Abandoned frame after one byte.
        timeout_frame(8'h05, 8'h00, 1'b0);
        check("vec_to_a", 32'(bus.o_data_a), 32'h05);

        // Opcode on the expiring tick is still accepted.
        frame(8'($urandom), 8'($urandom), 8'h22, 3, TICKS - 1, 1'b1, 0, 1'b0, 1'b0);

        // Dropped byte during WAIT_TX, then during EXEC.
        frame(8'($urandom), 8'($urandom), 8'h24, 0, 2, 1'b0, 2, 1'b0, 1'b0);
        frame(8'($urandom), 8'($urandom), 8'h26, 1, 0, 1'b0, 1, 1'b0, 1'b0);

        // Reset in WAIT_TX, then a clean frame right after release.
        frame(8'($urandom), 8'($urandom), 8'h25, 0, 0, 1'b0, 0, 1'b0, 1'b1);
        frame(8'h11, 8'h22, 8'h20, 0, 0, 1'b0, 0, 1'b0, 1'b0);

        // Stray tx_done in IDLE before a frame.
        frame(8'($urandom), 8'($urandom), 8'h27, 0, 0, 1'b0, 0, 1'b1, 1'b0);

        for (int k = 0; k < 24; k++) begin
            if (k % 8 == 5) begin
                timeout_frame(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            end else begin
                frame(8'($urandom), 8'($urandom),
                      {2'($urandom), op_tab[$urandom_range(0, 7)]},
                      int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
